// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/bubble sequencing, dmem handshake and load-use detection for the 3-stage core.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        ex_use_rs1,
    input  logic        ex_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        stall,
    output logic        flush,
    output logic        wb_bubble,
    output logic        mem_error,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    state_t state, state_n;
    logic [7:0] wait_cnt;
    logic wb_load_q;
    logic [4:0] wb_rd_q;
    logic lu, memop, stall_i, req_i;
    assign lu = wb_load_q && wb_rd_q != 5'd0 &&
                ((ex_use_rs1 && ex_rs1 == wb_rd_q) || (ex_use_rs2 && ex_rs2 == wb_rd_q));
    assign memop = ex_valid && (ex_is_load || ex_is_store);
    always_comb begin
        state_n = state;
        stall_i = 1'b0;
        req_i = 1'b0;
        case (state)
            RUN: begin
                // A load-use stall withholds the request: its address operand is stale.
                if (lu) begin
                    stall_i = 1'b1;
                end else if (memop) begin
                    req_i = 1'b1;
                    stall_i = !dmem_ready;
                    state_n = dmem_ready ? RUN : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                req_i = 1'b1;
                stall_i = !dmem_ready;
                state_n = dmem_ready ? RUN : (wait_cnt == TIMEOUT ? HALT : MEM_WAIT);
            end
            default: stall_i = 1'b1;
        endcase
    end
    assign stall = !reset && stall_i;
    assign dmem_req = !reset && req_i;
    assign flush = !reset && branch_taken && ex_valid && !stall_i;
    assign wb_bubble = stall;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            wait_cnt <= 8'd0;
            wb_load_q <= 1'b0;
            wb_rd_q <= 5'd0;
            mem_error <= 1'b0;
            stall_cycles <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            state <= state_n;
            if (state == RUN && state_n == MEM_WAIT)
                wait_cnt <= 8'd1;
            else if (state == MEM_WAIT && state_n == MEM_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == MEM_WAIT && state_n == HALT)
                mem_error <= 1'b1;
            wb_load_q <= stall ? 1'b0 : (ex_valid && ex_is_load);
            wb_rd_q <= stall ? 5'd0 : ex_rd;
            if (stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenario tests for hazard_controller with MEM_TIMEOUT=4.
module tb_hazard_controller;
    logic clock = 1'b0;
    logic reset, ex_valid, ex_is_load, ex_is_store, ex_use_rs1, ex_use_rs2, branch_taken, dmem_ready;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic dmem_req, stall, flush, wb_bubble, mem_error;
    logic [31:0] stall_cycles, flush_count;
    int checks = 0;
    int errors = 0;

    hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_use_rs1(ex_use_rs1),
        .ex_use_rs2(ex_use_rs2), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req), .stall(stall), .flush(flush),
        .wb_bubble(wb_bubble), .mem_error(mem_error), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    task automatic idle();
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_use_rs1 = 0; ex_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; branch_taken = 0; dmem_ready = 0;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        ex_valid = 1; ex_is_store = 1; branch_taken = 1;
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_comb: req=%0b stall=%0b flush=%0b required 0 0 0", dmem_req, stall, flush); end
        tick();
        tick();
        reset = 0;
        idle();
        settle();
        checks++; if (stall_cycles !== 0 || flush_count !== 0 || mem_error !== 1'b0) begin errors++; $display("FAIL reset_state: stall_cycles=%0d flush_count=%0d mem_error=%0b required 0 0 0", stall_cycles, flush_count, mem_error); end
        dmem_ready = 1;
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ready_ignored: req=%0b stall=%0b required 0 0", dmem_req, stall); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; dmem_ready = 1;
        settle();
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL lu_load: req=%0b stall=%0b required 1 0", dmem_req, stall); end
        tick();
        idle();
        ex_valid = 1; ex_use_rs1 = 1; ex_rs1 = 5; ex_rd = 6;
        settle();
        checks++; if (stall !== 1'b1 || wb_bubble !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL lu_stall: stall=%0b bubble=%0b req=%0b required 1 1 0", stall, wb_bubble, dmem_req); end
        tick();
        settle();
        checks++; if (stall !== 1'b0 || wb_bubble !== 1'b0) begin errors++; $display("FAIL lu_release: stall=%0b bubble=%0b required 0 0", stall, wb_bubble); end
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_count: stall_cycles=%0d required 1", stall_cycles); end
        tick();
        idle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 0; dmem_ready = 1;
        tick();
        idle();
        ex_valid = 1; ex_use_rs1 = 1; ex_rs1 = 0; ex_use_rs2 = 1; ex_rs2 = 0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_x0: stall=%0b required 0", stall); end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1; ex_is_load = 1; ex_rd = 7; dmem_ready = (i == 3);
            settle();
            checks++; if (dmem_req !== 1'b1 || stall !== (i != 3)) begin errors++; $display("FAIL wait_cycle%0d: req=%0b stall=%0b required 1 %0b", i, dmem_req, stall, i != 3); end
            tick();
        end
        idle();
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || stall_cycles !== 32'd3) begin errors++; $display("FAIL wait_done: req=%0b stall=%0b stall_cycles=%0d required 0 0 3", dmem_req, stall, stall_cycles); end
    endtask

    task automatic test_timeout();
        do_reset();
        ex_valid = 1; ex_is_store = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (dmem_req !== 1'b1 || stall !== 1'b1 || mem_error !== 1'b0) begin errors++; $display("FAIL to_wait%0d: req=%0b stall=%0b err=%0b required 1 1 0", i, dmem_req, stall, mem_error); end
            tick();
        end
        settle();
        checks++; if (mem_error !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b1 || stall_cycles !== 32'd5) begin errors++; $display("FAIL to_halt: err=%0b req=%0b stall=%0b stall_cycles=%0d required 1 0 1 5", mem_error, dmem_req, stall, stall_cycles); end
        dmem_ready = 1; branch_taken = 1;
        tick();
        settle();
        checks++; if (stall !== 1'b1 || dmem_req !== 1'b0 || flush !== 1'b0 || stall_cycles !== 32'd6) begin errors++; $display("FAIL to_stuck: stall=%0b req=%0b flush=%0b stall_cycles=%0d required 1 0 0 6", stall, dmem_req, flush, stall_cycles); end
        reset = 1;
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL halt_reset: req=%0b stall=%0b required 0 0", dmem_req, stall); end
        tick();
        reset = 0;
        idle();
        settle();
        checks++; if (mem_error !== 1'b0 || stall !== 1'b0 || stall_cycles !== 0) begin errors++; $display("FAIL halt_cleared: err=%0b stall=%0b stall_cycles=%0d required 0 0 0", mem_error, stall, stall_cycles); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_valid = 1; ex_is_store = 1;
        tick();
        tick();
        tick();
        settle();
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL mid_wait: req=%0b stall=%0b required 1 1", dmem_req, stall); end
        reset = 1;
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_bubble !== 1'b0) begin errors++; $display("FAIL mid_reset: req=%0b stall=%0b bubble=%0b required 0 0 0", dmem_req, stall, wb_bubble); end
        tick();
        reset = 0;
        settle();
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b1 || stall_cycles !== 0 || mem_error !== 1'b0) begin errors++; $display("FAIL post_reset: req=%0b stall=%0b stall_cycles=%0d err=%0b required 1 1 0 0", dmem_req, stall, stall_cycles, mem_error); end
        dmem_ready = 1;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_run: stall=%0b required 0", stall); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        ex_valid = 1; ex_is_load = 1; ex_rd = 3; dmem_ready = 1;
        tick();
        idle();
        ex_valid = 1; ex_use_rs2 = 1; ex_rs2 = 3; branch_taken = 1;
        settle();
        checks++; if (stall !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL br_stalled: stall=%0b flush=%0b required 1 0", stall, flush); end
        tick();
        settle();
        checks++; if (stall !== 1'b0 || flush !== 1'b1 || flush_count !== 0) begin errors++; $display("FAIL br_flush: stall=%0b flush=%0b flush_count=%0d required 0 1 0", stall, flush, flush_count); end
        tick();
        idle();
        branch_taken = 1;
        settle();
        checks++; if (flush !== 1'b0 || flush_count !== 32'd1) begin errors++; $display("FAIL br_done: flush=%0b flush_count=%0d required 0 1", flush, flush_count); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 3-stage core (fetch | execute | writeback). It generates the stall and flush controls for the fetch/execute pipeline register and the PC, and inserts writeback bubbles. It also owns the data-memory request/ready handshake for loads and stores in execute, and detects load-use hazards. It keeps stall and flush performance counters and flags a data-memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait before halting. Legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- ex_valid  in  1  execute holds a real instruction (not a flushed NOP).
- ex_is_load  in  1  execute instruction is a load.
- ex_is_store  in  1  execute instruction is a store.
- ex_rs1, ex_rs2  in  5  source register indices of the execute instruction.
- ex_use_rs1, ex_use_rs2  in  1  the corresponding source is actually read.
- ex_rd  in  5  destination register of the execute instruction.
- branch_taken  in  1  execute resolved a taken branch or jump.
- dmem_ready  in  1  memory completes the current request this cycle.
- dmem_req  out  1  request to data memory; held until dmem_ready.
- stall  out  1  hold PC and the fetch/execute pipeline register.
- flush  out  1  load NOP 0x00000013 into the fetch/execute register and redirect fetch.
- wb_bubble  out  1  load a bubble into the execute/writeback register.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  32  count of cycles with stall=1.
- flush_count  out  32  count of cycles with flush=1.

## Operation
- Registered writeback tracking: wb_load_q and wb_rd_q capture ex_valid&ex_is_load and ex_rd on every edge with stall=0. On an edge with stall=1 they capture 0 (bubble).
- Load-use hazard (combinational), lu = wb_load_q & wb_rd_q!=0 & ((ex_use_rs1 & ex_rs1==wb_rd_q) | (ex_use_rs2 & ex_rs2==wb_rd_q)).
  - Load data is not forwardable; the stall lets the register file write complete before execute re-reads its operands.
- memop = ex_valid & (ex_is_load | ex_is_store).
- FSM states:
  - RUN:
    - lu=1: stall=1, dmem_req=0 (address operand stale). Stay in RUN.
    - memop & ~lu: dmem_req=1.
      - dmem_ready=1: stall=0, instruction advances.
      - Otherwise: stall=1, go to MEM_WAIT, wait_cnt←1.
    - Otherwise: stall=0.
  - MEM_WAIT: dmem_req=1, stall=~dmem_ready.
    - dmem_ready: go to RUN.
    - Else if wait_cnt==MEM_TIMEOUT: go to HALT, mem_error←1.
    - Else wait_cnt←wait_cnt+1.
  - HALT: stall=1, dmem_req=0, flush=0. Exit only by reset.
- flush = branch_taken & ex_valid & ~stall. A branch evaluated with stale operands during a load-use stall is ignored; it is re-evaluated next cycle.
- wb_bubble = stall.
- Counters: stall_cycles increments when stall=1, flush_count increments when flush=1. Both saturate at 0xFFFFFFFF (no wrap).
- Reset values: state RUN, wait_cnt 0, wb_load_q 0, wb_rd_q 0, mem_error 0, both counters 0.
  - While reset=1, stall, flush, wb_bubble and dmem_req are forced to 0 combinationally.
  - Reset during MEM_WAIT or HALT drops dmem_req in the same cycle and returns to RUN at the edge.

## Timing
- stall, flush, wb_bubble, dmem_req: combinational from registered state and same-cycle inputs, and consumed at the same edge.
- Load-use: exactly 1 stall cycle when the hazard exists; execute re-reads operands in the following cycle.
- Memory op with dmem_ready in its first cycle: 0 stall cycles.
  - If dmem_ready first arrives N cycles after dmem_req first asserts: N stall cycles (N ≤ MEM_TIMEOUT).
- Timeout: dmem_ready absent for MEM_TIMEOUT+1 consecutive request cycles. The FSM enters HALT at the next edge and mem_error reads 1 from that cycle on.
- dmem_ready outside a request (dmem_req=0) is ignored.
- Flush: asserted for exactly the cycle branch_taken is seen unstalled; flush_count updates at the following edge.

## Test plan
- Reset mid-wait: store, dmem_ready low for 3 cycles, reset for 1 cycle. Required: dmem_req=0 during the reset cycle; state RUN, counters 0, mem_error 0 afterwards.
- Load-use: load x5 completes; next instruction uses rs1=x5. Required: stall=1 and wb_bubble=1 for exactly 1 cycle, dmem_req=0 in that cycle, stall_cycles=1.
  - Repeat with rd=x0: no stall.
- Memory wait: load with dmem_ready arriving 3 cycles after the request. Required: dmem_req high for 4 cycles, stall high for the first 3, back in RUN after the edge of the ready cycle, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, store, dmem_ready never asserted. Required: mem_error=1 after 5 request cycles, dmem_req=0 and stall=1 thereafter, stall_cycles keeps counting.
- Branch vs stall: branch_taken=1 while lu=1. Required: flush=0. Next cycle, with no hazard and branch_taken=1: flush=1 for 1 cycle, flush_count=1.
